// File: rtl/manchester_decode.sv
// manchester_decode: recovers one header+data+parity frame from a Manchester line.
// Build option MAN_DEC_RESYNC_EN: realign the sample grid on mid-bit edges.
module manchester_decode #(
  parameter int C_HALF_CLKS  = 3,
  parameter int C_SAMPLE_OFS = 1,
  parameter int C_DATA_W     = 16,
  parameter int C_HDR_HALF   = 3,
  parameter int C_IDLE_MIN   = 3
) (
  input  logic                I_sys_clk,
  input  logic                I_rst_n,
  input  logic                I_dec_en,
  input  logic                I_line,
  output logic [C_DATA_W-1:0] O_data,
  output logic                O_dec_done,
  output logic                O_par_err,
  output logic                O_man_err
);

  localparam int C_LAST = C_HDR_HALF + 2 * C_DATA_W + 1;
  localparam int CW = $clog2(C_HALF_CLKS);
  localparam int HW = $clog2(C_LAST + 1);
  localparam int IW = $clog2(C_IDLE_MIN + 1);

  localparam logic [CW-1:0] C_OFS  = CW'(C_SAMPLE_OFS);
  localparam logic [CW-1:0] C_CMAX = CW'(C_HALF_CLKS - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [HW-1:0] C_TERM = HW'(C_LAST);
  localparam logic [HW-1:0] C_PARH = HW'(C_LAST - 1);
  localparam logic [HW-1:0] C_HEND = HW'(C_HDR_HALF - 1);
  localparam logic [IW-1:0] C_IMIN = IW'(C_IDLE_MIN);
  localparam logic          C_HODD = 1'(C_HDR_HALF % 2);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

  state_t              S_state;
  logic                S_line_s1;
  logic                S_line_s2;
  logic [CW-1:0]       S_cnt_clk;
  logic [HW-1:0]       S_cnt_half;
  logic [IW-1:0]       S_low_cnt;
  logic [C_DATA_W-1:0] S_shift;
  logic                S_first;
  logic                S_par;
  logic                S_pend;
  logic                S_man;

  logic [CW-1:0]       S_clk_nxt;
  logic [HW-1:0]       S_half_nxt;
  logic                S_at_smp;
  logic                S_second;
  logic                S_last;
  logic                S_resync;

  always_comb begin
    S_clk_nxt  = S_cnt_clk + 1'b1;
    S_half_nxt = S_cnt_half;
    if (S_cnt_clk == C_CMAX) begin
      S_clk_nxt  = '0;
      S_half_nxt = S_cnt_half + 1'b1;
    end
  end

  assign S_at_smp = S_cnt_clk == C_OFS;
  assign S_second = S_cnt_half[0] ^ C_HODD;
  assign S_last   = S_cnt_half == C_TERM;

`ifdef MAN_DEC_RESYNC_EN
  logic S_line_s3;
  logic S_edge;

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) S_line_s3 <= 1'b0;
    else          S_line_s3 <= S_line_s2;
  end

  assign S_edge = S_line_s2 ^ S_line_s3;
  // A late edge after an equal second-half sample is the real mid-bit edge.
  assign S_resync = (S_state == DATA) && S_edge &&
    ((!S_second && (S_cnt_clk > C_OFS)) ||
     (S_second && ((S_cnt_clk <= C_OFS) || S_pend)));
`else
  assign S_resync = 1'b0;
`endif

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      S_state    <= IDLE;
      S_line_s1  <= 1'b0;
      S_line_s2  <= 1'b0;
      S_cnt_clk  <= '0;
      S_cnt_half <= '0;
      S_low_cnt  <= '0;
      S_shift    <= '0;
      S_first    <= 1'b0;
      S_par      <= 1'b0;
      S_pend     <= 1'b0;
      S_man      <= 1'b0;
      O_data     <= '0;
      O_dec_done <= 1'b0;
      O_par_err  <= 1'b0;
      O_man_err  <= 1'b0;
    end else begin
      S_line_s1  <= I_line;
      S_line_s2  <= S_line_s1;
      O_dec_done <= 1'b0;
      O_par_err  <= 1'b0;
      O_man_err  <= 1'b0;
      if (!I_dec_en) begin
        S_state    <= IDLE;
        S_cnt_clk  <= '0;
        S_cnt_half <= '0;
        S_low_cnt  <= '0;
        S_pend     <= 1'b0;
        S_man      <= 1'b0;
      end else begin
        unique case (S_state)
          IDLE: begin
            if (!S_line_s2) begin
              if (S_low_cnt != C_IMIN) S_low_cnt <= S_low_cnt + 1'b1;
            end else begin
              S_low_cnt <= '0;
              if (S_low_cnt == C_IMIN) begin
                S_state    <= HDR;
                S_cnt_clk  <= C_ONE;
                S_cnt_half <= '0;
                S_pend     <= 1'b0;
                S_man      <= 1'b0;
              end
            end
          end
          HDR: begin
            S_cnt_clk  <= S_clk_nxt;
            S_cnt_half <= S_half_nxt;
            if (S_at_smp && !S_line_s2) begin
              S_state   <= IDLE;
              S_low_cnt <= '0;
            end else if (S_at_smp && (S_cnt_half == C_HEND)) begin
              S_state <= DATA;
            end
          end
          DATA: begin
            if (S_resync) begin
              S_cnt_clk <= C_ONE;
              if (!S_second) S_cnt_half <= S_cnt_half + 1'b1;
            end else begin
              if (!(S_at_smp && S_last)) begin
                S_cnt_clk  <= S_clk_nxt;
                S_cnt_half <= S_half_nxt;
              end
              if (S_at_smp) begin
                if (!S_second) begin
                  S_first <= S_line_s2;
                  S_man   <= S_man | S_pend;
                  S_pend  <= 1'b0;
                  if (S_cnt_half == C_PARH) S_par <= S_line_s2;
                  else S_shift <= {S_shift[C_DATA_W-2:0], S_line_s2};
                end else if (S_last) begin
                  S_state    <= DONE;
                  O_data     <= S_shift;
                  O_dec_done <= 1'b1;
                  O_par_err  <= ~(^{S_par, S_shift});
                  O_man_err  <= S_man | (S_line_s2 == S_first);
                end else begin
                  S_pend <= S_line_s2 == S_first;
                end
              end
            end
          end
          DONE: begin
            S_state    <= IDLE;
            S_low_cnt  <= '0;
            S_cnt_clk  <= '0;
            S_cnt_half <= '0;
            S_pend     <= 1'b0;
            S_man      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_manchester_decode.sv
// Directed bench for manchester_decode: frames, errors, runt, reset and enable aborts.
module tb_manchester_decode;

  logic        I_sys_clk;
  logic        I_rst_n;
  logic        I_dec_en;
  logic        I_line;
  logic [15:0] O_data;
  logic        O_dec_done;
  logic        O_par_err;
  logic        O_man_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int done_cnt = 0;
  int last_cyc = 0;
  int orphan = 0;
  int bad_chg = 0;
  int d0;
  logic [15:0] last_data = '0;
  logic [15:0] prev_data = '0;
  logic        last_par = 1'b0;
  logic        last_man = 1'b0;

  manchester_decode dut (
    .I_sys_clk (I_sys_clk),
    .I_rst_n   (I_rst_n),
    .I_dec_en  (I_dec_en),
    .I_line    (I_line),
    .O_data    (O_data),
    .O_dec_done(O_dec_done),
    .O_par_err (O_par_err),
    .O_man_err (O_man_err)
  );

  initial I_sys_clk = 1'b0;
  always #17 I_sys_clk = ~I_sys_clk;

  always @(posedge I_sys_clk) cyc <= cyc + 1;

  always @(negedge I_sys_clk) begin
    if (O_dec_done) begin
      done_cnt  = done_cnt + 1;
      last_cyc  = cyc;
      last_data = O_data;
      last_par  = O_par_err;
      last_man  = O_man_err;
    end
    if ((O_par_err || O_man_err) && !O_dec_done) orphan = orphan + 1;
    if (I_rst_n && (O_data !== prev_data) && !O_dec_done)
      bad_chg = bad_chg + 1;
    prev_data = O_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    I_line = v;
    repeat (n) begin
      @(posedge I_sys_clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [15:0] d, input logic p,
                            input int s_lo, input int s_hi,
                            input int frc, input int n_half);
    logic b;
    logic v;
    int   len;
    hold(1'b0, 20);
    rise_cyc = cyc;
    hold(1'b1, 9);
    for (int i = 0; i < n_half; i++) begin
      b = (i / 2 < 16) ? d[15 - i / 2] : p;
      v = (i % 2 == 0) ? b : ~b;
      if (i / 2 == frc) v = 1'b1;
      len = (i / 2 >= s_lo && i / 2 <= s_hi) ? 4 : 3;
      hold(v, len);
    end
    I_line = 1'b0;
  endtask

  initial begin
    I_rst_n  = 1'b0;
    I_dec_en = 1'b1;
    I_line   = 1'b0;
    repeat (3) @(posedge I_sys_clk);
    #1;
    chk("rst_data", 32'(O_data), 32'h0);
    chk("rst_done", 32'(O_dec_done), 32'h0);
    chk("rst_par", 32'(O_par_err), 32'h0);
    chk("rst_man", 32'(O_man_err), 32'h0);
    I_rst_n = 1'b1;
    hold(1'b0, 2);

    d0 = done_cnt;
    send_frame(16'hA5C3, 1'b1, -1, -1, -1, 34);
    hold(1'b0, 20);
    chk("a5c3_done", 32'(done_cnt - d0), 32'd1);
    chk("a5c3_lat", 32'(last_cyc - rise_cyc), 32'd112);
    chk("a5c3_data", 32'(last_data), 32'hA5C3);
    chk("a5c3_par", 32'(last_par), 32'h0);
    chk("a5c3_man", 32'(last_man), 32'h0);

    d0 = done_cnt;
    send_frame(16'hFFFF, 1'b1, -1, -1, -1, 34);
    hold(1'b0, 20);
    chk("ffff_done", 32'(done_cnt - d0), 32'd1);
    chk("ffff_data", 32'(last_data), 32'hFFFF);
    chk("ffff_par", 32'(last_par), 32'h0);
    chk("ffff_man", 32'(last_man), 32'h0);

    d0 = done_cnt;
    send_frame(16'h0000, 1'b1, -1, -1, -1, 34);
    hold(1'b0, 20);
    chk("0000_done", 32'(done_cnt - d0), 32'd1);
    chk("0000_data", 32'(last_data), 32'h0000);
    chk("0000_par", 32'(last_par), 32'h0);
    chk("0000_man", 32'(last_man), 32'h0);

    d0 = done_cnt;
    send_frame(16'h0001, 1'b1, -1, -1, -1, 34);
    hold(1'b0, 20);
    chk("par_done", 32'(done_cnt - d0), 32'd1);
    chk("par_data", 32'(last_data), 32'h0001);
    chk("par_par", 32'(last_par), 32'h1);
    chk("par_man", 32'(last_man), 32'h0);

    // O_data bit 7 is the ninth bit on the wire
    d0 = done_cnt;
    send_frame(16'h1234, 1'b0, -1, -1, 8, 34);
    hold(1'b0, 20);
    chk("man_done", 32'(done_cnt - d0), 32'd1);
    chk("man_man", 32'(last_man), 32'h1);
    chk("man_data", 32'(last_data), 32'h12B4);
    chk("man_par", 32'(last_par), 32'h1);

    d0 = done_cnt;
    hold(1'b0, 20);
    hold(1'b1, 4);
    hold(1'b0, 20);
    chk("runt_done", 32'(done_cnt - d0), 32'd0);
    send_frame(16'h5A5A, 1'b1, -1, -1, -1, 34);
    hold(1'b0, 20);
    chk("runt_next_done", 32'(done_cnt - d0), 32'd1);
    chk("runt_next_data", 32'(last_data), 32'h5A5A);

    d0 = done_cnt;
    send_frame(16'h5A5A, 1'b1, -1, -1, -1, 17);
    I_rst_n = 1'b0;
    hold(1'b0, 2);
    chk("rstmid_data", 32'(O_data), 32'h0);
    chk("rstmid_flags", 32'({O_dec_done, O_par_err, O_man_err}), 32'h0);
    I_rst_n = 1'b1;
    hold(1'b0, 10);
    chk("rstmid_done", 32'(done_cnt - d0), 32'd0);
    send_frame(16'h5A5A, 1'b1, -1, -1, -1, 34);
    hold(1'b0, 20);
    chk("rstmid_next_done", 32'(done_cnt - d0), 32'd1);
    chk("rstmid_next_data", 32'(O_data), 32'h5A5A);

    d0 = done_cnt;
    send_frame(16'hFFFF, 1'b1, -1, -1, -1, 17);
    I_dec_en = 1'b0;
    hold(1'b0, 2);
    I_dec_en = 1'b1;
    hold(1'b0, 10);
    chk("en_done", 32'(done_cnt - d0), 32'd0);
    chk("en_hold", 32'(O_data), 32'h5A5A);
    send_frame(16'h5A5A, 1'b1, -1, -1, -1, 34);
    hold(1'b0, 20);
    chk("en_next_done", 32'(done_cnt - d0), 32'd1);
    chk("en_next_data", 32'(last_data), 32'h5A5A);
    chk("en_next_errs", 32'({last_par, last_man}), 32'h0);

    d0 = done_cnt;
    send_frame(16'hC3C3, 1'b1, 4, 8, -1, 34);
    hold(1'b0, 30);
    chk("drift_done", 32'(done_cnt - d0), 32'd1);
`ifdef MAN_DEC_RESYNC_EN
    chk("drift_data", 32'(last_data), 32'hC3C3);
    chk("drift_errs", 32'({last_par, last_man}), 32'h0);
`else
    chk("drift_bad", 32'(last_man || (last_data != 16'hC3C3)), 32'h1);
`endif

    chk("orphan_flags", 32'(orphan), 32'd0);
    chk("data_stable", 32'(bad_chg), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
